// File: rtl/alu_checker.sv
// Self-checking ALU exerciser: issues LFSR operands, compares in-order results.
// Latency: operands offered the cycle after i_start; error count updates one cycle after a result.
// Backpressure: holds a/b/op while i_alu_ready is low; stops offering when the expected-result FIFO is full.

module alu_checker_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module alu_checker #(
    parameter int          WIDTH = 32,
    parameter int          TESTS = 32,
    parameter int          DEPTH = 4,
    parameter int          MODE  = 0,
    parameter logic [31:0] SEED  = 32'h1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_alu_ready,
    input  logic             i_alu_res_valid,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    output logic             o_alu_valid,
    output logic             o_done,
    output logic             o_pass,
    output logic [15:0]      o_err_count
);
    localparam int          CW     = $clog2(DEPTH) + 1;
    localparam logic [31:0] POLY   = 32'h80200003;
    localparam logic [1:0]  OP_NOP = 2'b00;
    localparam logic [1:0]  OP_ADD = 2'b01;
    localparam logic [1:0]  OP_SUB = 2'b10;
    localparam logic [1:0]  OP_AND = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    state_t           state;
    logic [31:0]      lfsr;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [15:0]      issue_cnt;
    logic [15:0]      err_next;
    logic [WIDTH-1:0] exp_dat;
    logic [WIDTH-1:0] head_dat;
    logic [CW-1:0]    fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             issue;
    logic             pop;
    logic             bad;
    logic             start_run;
    logic [31:0]      seed_s1;
    logic [31:0]      seed_s2;
    logic [31:0]      run_s1;
    logic [31:0]      run_s2;

    // The a/b/op registers always hold the pending operation, so they stay put under backpressure.
    assign o_alu_valid = (state == RUN) && !fifo_full;
    assign o_alu_op    = o_alu_valid ? op_q : OP_NOP;
    assign o_alu_a     = a_q;
    assign o_alu_b     = b_q;

    assign issue     = o_alu_valid && i_alu_ready;
    assign pop       = i_alu_res_valid && !fifo_empty;
    assign bad       = i_alu_res_valid && (fifo_empty || (i_alu_result != head_dat));
    assign err_next  = (bad && (o_err_count != 16'hFFFF)) ? o_err_count + 16'd1 : o_err_count;
    assign start_run = i_start && ((state == IDLE) || (state == DONE));

    assign seed_s1 = lfsr_step(SEED);
    assign seed_s2 = lfsr_step(seed_s1);
    assign run_s1  = lfsr_step(lfsr);
    assign run_s2  = lfsr_step(run_s1);

    always_comb begin
        exp_dat = a_q + b_q;
        case (op_q)
            OP_SUB:  exp_dat = a_q - b_q;
            OP_AND:  exp_dat = a_q & b_q;
            default: exp_dat = a_q + b_q;
        endcase
    end

    alu_checker_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (start_run),
        .push_vld (issue),
        .push_dat (exp_dat),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            lfsr        <= SEED;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            issue_cnt   <= '0;
            o_err_count <= '0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
        end else begin
            o_err_count <= err_next;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state       <= RUN;
                        lfsr        <= seed_s2;
                        a_q         <= seed_s1[WIDTH-1:0];
                        b_q         <= seed_s2[WIDTH-1:0];
                        op_q        <= OP_ADD;
                        issue_cnt   <= '0;
                        o_err_count <= '0;
                        o_done      <= 1'b0;
                        o_pass      <= 1'b0;
                    end else if (state == DONE) begin
                        o_pass <= (err_next == 16'd0);
                    end
                end
                RUN: begin
                    if (issue) begin
                        lfsr      <= run_s2;
                        a_q       <= run_s1[WIDTH-1:0];
                        b_q       <= run_s2[WIDTH-1:0];
                        issue_cnt <= issue_cnt + 16'd1;
                        if (MODE == 1) begin
                            op_q <= (op_q == OP_AND) ? OP_ADD : op_q + 2'd1;
                        end else begin
                            op_q <= OP_ADD;
                        end
                        if (issue_cnt == 16'(TESTS - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (fifo_cnt == CW'(1))) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                        o_pass <= (err_next == 16'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width, legal 8..32.
REQ-002 SHALL have parameter TESTS, default 32, number of operations issued per run, legal 1..65535.
REQ-003 SHALL have parameter DEPTH, default 4, expected-result FIFO entries, power of two, legal 2..16.
REQ-004 SHALL have parameter MODE, default 0: 0 = ADD only; 1 = rotate ADD, SUB, AND.
REQ-005 SHALL have parameter SEED, default 32'h1, LFSR start value, nonzero.
REQ-006 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_start  input  1  one-cycle pulse that begins a run.
REQ-009 SHALL have port i_alu_ready  input  1  ALU accepts operation this cycle.
REQ-010 SHALL have port i_alu_res_valid  input  1  i_alu_result valid this cycle.
REQ-011 SHALL have port i_alu_result  input  WIDTH  ALU result, in issue order.
REQ-012 SHALL have ports o_alu_a, o_alu_b  output  WIDTH  operands.
REQ-013 SHALL have port o_alu_op  output  2  opcode: 00 NOP, 01 ADD, 10 SUB, 11 AND.
REQ-014 SHALL have port o_alu_valid  output  1  operation offered this cycle.
REQ-015 SHALL have ports o_done  output  1  run complete; o_pass  output  1  run had zero errors.
REQ-016 SHALL have port o_err_count  output  16  mismatches plus unexpected results, saturating at 16'hFFFF.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE -> RUN on i_start; DONE -> RUN on i_start; i_start ignored in RUN and DRAIN.
REQ-019 Entering RUN SHALL clear o_err_count, o_done, o_pass, issue counter, FIFO, and reload LFSR with SEED.
REQ-020 Operands SHALL come from a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003): a = low WIDTH bits after one step, b = low WIDTH bits after a second step; LFSR advances two steps per issue only.
REQ-021 Issue k (0-based) opcode: MODE 0 -> ADD; MODE 1 -> ADD, SUB, AND for k mod 3 = 0, 1, 2.
REQ-022 o_alu_valid SHALL be 1 in RUN when the FIFO is not full; an issue occurs when o_alu_valid and i_alu_ready are both 1 on a rising edge.
REQ-023 a, b, op SHALL hold stable while o_alu_valid = 1 and i_alu_ready = 0.
REQ-024 On issue, expected result SHALL be pushed: a+b, a-b, or a&b, truncated mod 2^WIDTH.
REQ-025 When o_alu_valid = 0, o_alu_op SHALL be NOP.
REQ-026 RUN -> DRAIN on the cycle of issue number TESTS.
REQ-027 On i_alu_res_valid with FIFO non-empty: pop and compare; mismatch increments o_err_count.
REQ-028 On i_alu_res_valid with FIFO empty (any state, including IDLE and DONE): o_err_count increments, nothing pops.
REQ-029 Simultaneous issue and result in one cycle SHALL push and pop together; occupancy unchanged; full-FIFO check uses occupancy before the edge.
REQ-030 DRAIN -> DONE when the FIFO becomes empty; in DONE, o_done = 1 and o_pass = (o_err_count == 0); both are registered, valid the cycle after the final pop.
REQ-031 Comparison SHALL be combinational against FIFO head; error count updates one cycle after the result.

Reset
REQ-032 i_rst = 1 SHALL immediately force IDLE, empty FIFO, LFSR = SEED, o_alu_valid = 0, o_alu_op = NOP, o_alu_a = o_alu_b = 0, o_err_count = 0, o_done = 0, o_pass = 0.
REQ-033 Reset mid-run SHALL discard all outstanding expected results; no i_start is implied on release.

Verification
REQ-034 Bench: reset, i_start, ideal ALU (ready = 1, result 1 cycle later, correct), defaults -> exactly 32 issues, o_done = 1, o_pass = 1, o_err_count = 0.
REQ-035 Bench: MODE = 1, WIDTH = 8, TESTS = 6, ideal ALU -> op sequence 01,10,11,01,10,11; SUB wraps (e.g. a = 8'h03, b = 8'h05 expects 8'hFE); o_pass = 1.
REQ-036 Bench: DEPTH = 4, ALU ready = 1 but results withheld -> exactly 4 issues then o_alu_valid = 0; releasing one result -> fifth issue next cycle.
REQ-037 Bench: ALU corrupts result of issue 3 (xor 1) -> o_done = 1, o_pass = 0, o_err_count = 1.
REQ-038 Bench: i_alu_res_valid pulse while IDLE -> o_err_count = 1; i_start clears it to 0.
REQ-039 Bench: assert i_rst after 10 issues, release, i_start -> first operands identical to first run's, run passes.
